// File: rtl/slot_sequencer_if.sv
// Signal bundle between the slot sequencer and its environment: trigger inputs,
// slot periods, and the registered slot/frame status outputs.
interface slot_sequencer_if #(
    parameter int TS_W  = 16,
    parameter int DIV_W = 16,
    parameter int OVR_W = 8
);
    // No back-pressure anywhere: tick, slot_start, frame_start and frame_done are
    // single-cycle strobes, valid in the cycle they are high and never stalled.
    logic             tick;
    logic             ext_sync;
    logic             sync_enabled;
    logic             int_ext_sync;
    logic [DIV_W-1:0] in_sync_div;
    logic [TS_W-1:0]  ts_time_0;
    logic [TS_W-1:0]  ts_time_1;
    logic [TS_W-1:0]  ts_time_2;
    logic [TS_W-1:0]  ts_time_3;
    logic [1:0]       slot;
    logic             slot_start;
    logic             frame_start;
    logic             frame_done;
    logic             busy;
    logic [OVR_W-1:0] overrun_cnt;
    logic             state_dbg;

    modport master (
        output tick, ext_sync, sync_enabled, int_ext_sync, in_sync_div,
               ts_time_0, ts_time_1, ts_time_2, ts_time_3,
        input  slot, slot_start, frame_start, frame_done, busy, overrun_cnt, state_dbg
    );

    modport slave (
        input  tick, ext_sync, sync_enabled, int_ext_sync, in_sync_div,
               ts_time_0, ts_time_1, ts_time_2, ts_time_3,
        output slot, slot_start, frame_start, frame_done, busy, overrun_cnt, state_dbg
    );
endinterface

// File: rtl/slot_sequencer.sv
// Frame trigger generation (internal divider or synchronized external pin) and a
// four-slot walker with per-slot programmable periods; all outputs registered.
module slot_sequencer #(
    parameter int TS_W  = 16,
    parameter int DIV_W = 16,
    parameter int OVR_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    slot_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, SLOT} state_t;

    state_t           state_q, state_n;
    logic             sync1_q, sync2_q, hist_q;
    logic [DIV_W-1:0] div_q, div_limit;
    logic             div_run, int_trig, ext_trig, trig;
    logic [TS_W-1:0]  cnt_q, cnt_n, period_q, period_n, ts_sel;
    logic [1:0]       slot_q, slot_n;
    logic             slot_start_q, slot_start_n;
    logic             frame_start_q, frame_start_n;
    logic             frame_done_q, frame_done_n;
    logic             busy_q, busy_n;
    logic [OVR_W-1:0] ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= bus.ext_sync;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign ext_trig = sync2_q & ~hist_q & bus.sync_enabled & bus.int_ext_sync;

    // A zero ratio compares against 0, so every tick fires; a count already past a
    // lowered limit simply wraps around before matching again.
    assign div_run   = bus.sync_enabled & ~bus.int_ext_sync;
    assign div_limit = (bus.in_sync_div == '0) ? '0 : bus.in_sync_div - DIV_W'(1);
    assign int_trig  = div_run & bus.tick & (div_q == div_limit);
    assign trig      = int_trig | ext_trig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           div_q <= '0;
        else if (!div_run)    div_q <= '0;
        else if (bus.tick)    div_q <= int_trig ? '0 : div_q + DIV_W'(1);
    end

    always_comb begin
        state_n       = state_q;
        slot_n        = slot_q;
        cnt_n         = cnt_q;
        period_n      = period_q;
        slot_start_n  = 1'b0;
        frame_start_n = 1'b0;
        ts_sel        = '0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_n       = SLOT;
                    slot_n        = 2'd0;
                    cnt_n         = TS_W'(1);
                    slot_start_n  = 1'b1;
                    frame_start_n = 1'b1;
                end
            end
            SLOT: begin
                if (cnt_q == period_q) begin
                    if (slot_q != 2'd3) begin
                        slot_n       = slot_q + 2'd1;
                        cnt_n        = TS_W'(1);
                        slot_start_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        slot_n  = 2'd0;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt_q + TS_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        case (slot_n)
            2'd0:    ts_sel = bus.ts_time_0;
            2'd1:    ts_sel = bus.ts_time_1;
            2'd2:    ts_sel = bus.ts_time_2;
            default: ts_sel = bus.ts_time_3;
        endcase
        // Periods are captured only as a slot begins, so mid-slot edits wait.
        if (slot_start_n) period_n = (ts_sel == '0) ? TS_W'(1) : ts_sel;
        busy_n       = (state_n == SLOT);
        frame_done_n = busy_n && (slot_n == 2'd3) && (cnt_n == period_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q        <= 2'd0;
            cnt_q         <= '0;
            period_q      <= '0;
            slot_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_n;
            slot_q        <= slot_n;
            cnt_q         <= cnt_n;
            period_q      <= period_n;
            slot_start_q  <= slot_start_n;
            frame_start_q <= frame_start_n;
            frame_done_q  <= frame_done_n;
            busy_q        <= busy_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        ovr_q <= '0;
        else if (state_q == SLOT && trig && ovr_q != '1)   ovr_q <= ovr_q + OVR_W'(1);
    end

    assign bus.slot        = slot_q;
    assign bus.slot_start  = slot_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;
    assign bus.overrun_cnt = ovr_q;
    assign bus.state_dbg   = (state_q == SLOT);
endmodule

// File: tb/tb_slot_sequencer.sv
// Directed bench for slot_sequencer: stimulus pushes hand-computed slot/frame
// events into a queue, a negedge monitor pops and compares them as they appear.
module tb_slot_sequencer;
    localparam int W = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slot_sequencer_if bus ();
    slot_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_ev, exp_ev;
    int n_checks = 0;
    int n_pass   = 0;
    int idx      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Event record: {frame_start, slot_start, frame_done, slot, busy-cycle index}
    function automatic logic [W-1:0] ev(input bit fs, input bit ss, input bit fd,
                                        input int s, input int i);
        return {fs, ss, fd, 2'(s), 12'(i)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) idx = 0;
        else begin
            if (bus.frame_start) idx = 1;
            else if (bus.busy)   idx++;
            if (bus.frame_start || bus.slot_start || bus.frame_done) begin
                got_ev = ev(bus.frame_start, bus.slot_start, bus.frame_done, int'(bus.slot), idx);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got %h expected none", got_ev);
                end else begin
                    exp_ev = exp_q.pop_front();
                    check("event", int'(got_ev), int'(exp_ev));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        bus.tick = 1'b1;
        step(1);
        bus.tick = 1'b0;
    endtask

    task automatic wait_busy_low(input int bound, input string name);
        int n = 0;
        while (bus.busy && n < bound) begin
            step(1);
            n++;
        end
        check(name, int'(bus.busy), 0);
    endtask

    task automatic wait_slot(input int k, input int bound, input string name);
        int n = 0;
        while (int'(bus.slot) != k && n < bound) begin
            step(1);
            n++;
        end
        check(name, int'(bus.slot), k);
    endtask

    task automatic set_ts(input int t0, input int t1, input int t2, input int t3);
        bus.ts_time_0 = 16'(t0);
        bus.ts_time_1 = 16'(t1);
        bus.ts_time_2 = 16'(t2);
        bus.ts_time_3 = 16'(t3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick = 1'b0;
        bus.ext_sync = 1'b0;
        bus.sync_enabled = 1'b0;
        bus.int_ext_sync = 1'b0;
        bus.in_sync_div = '0;
        set_ts(0, 0, 0, 0);
        step(2);
        check("rst_slot", int'(bus.slot), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ovr", int'(bus.overrun_cnt), 0);
        check("rst_pulses", int'({bus.slot_start, bus.frame_start, bus.frame_done}), 0);
        rst_n = 1'b1;
        step(2);

        // Internal divider 4, tick every cycle
        set_ts(5, 3, 2, 1);
        bus.in_sync_div = 16'd4;
        exp_q.push_back(ev(1, 1, 0, 0, 1));
        exp_q.push_back(ev(0, 1, 0, 1, 6));
        exp_q.push_back(ev(0, 1, 0, 2, 9));
        exp_q.push_back(ev(0, 1, 1, 3, 11));
        bus.sync_enabled = 1'b1;
        bus.tick = 1'b1;
        step(3);
        check("t1_no_early_start", int'(bus.frame_start), 0);
        step(1);
        bus.tick = 1'b0;
        check("t1_start_after_4_ticks", int'(bus.frame_start), 1);
        wait_busy_low(20, "t1_frame_ends");
        check("t1_idle_slot", int'(bus.slot), 0);

        // Zero period in slot 1, divider 0 acts as 1
        set_ts(2, 0, 2, 2);
        bus.in_sync_div = 16'd0;
        exp_q.push_back(ev(1, 1, 0, 0, 1));
        exp_q.push_back(ev(0, 1, 0, 1, 3));
        exp_q.push_back(ev(0, 1, 0, 2, 4));
        exp_q.push_back(ev(0, 1, 0, 3, 6));
        exp_q.push_back(ev(0, 0, 1, 3, 7));
        tick_pulse();
        check("t2_start", int'(bus.frame_start), 1);
        wait_busy_low(20, "t2_frame_ends");

        // External pin: first edge accepted, second dropped, third accepted
        set_ts(10, 10, 10, 10);
        bus.int_ext_sync = 1'b1;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(ev(1, 1, 0, 0, 1));
            exp_q.push_back(ev(0, 1, 0, 1, 11));
            exp_q.push_back(ev(0, 1, 0, 2, 21));
            exp_q.push_back(ev(0, 1, 0, 3, 31));
            exp_q.push_back(ev(0, 0, 1, 3, 40));
        end
        step(2);
        bus.ext_sync = 1'b1;
        step(2);
        check("t3_ext_not_yet", int'(bus.frame_start), 0);
        step(1);
        check("t3_ext_latency", int'(bus.frame_start), 1);
        step(1);
        bus.ext_sync = 1'b0;
        step(21);
        bus.ext_sync = 1'b1;
        step(4);
        bus.ext_sync = 1'b0;
        step(1);
        check("t3_overrun_one", int'(bus.overrun_cnt), 1);
        step(20);
        bus.ext_sync = 1'b1;
        step(2);
        check("t3_ext2_not_yet", int'(bus.frame_start), 0);
        step(1);
        check("t3_ext2_latency", int'(bus.frame_start), 1);
        step(1);
        bus.ext_sync = 1'b0;
        wait_busy_low(60, "t3_frame_ends");
        check("t3_overrun_still_one", int'(bus.overrun_cnt), 1);
        bus.int_ext_sync = 1'b0;

        // Slot 2 period raised while slot 1 runs
        set_ts(2, 2, 4, 1);
        exp_q.push_back(ev(1, 1, 0, 0, 1));
        exp_q.push_back(ev(0, 1, 0, 1, 3));
        exp_q.push_back(ev(0, 1, 0, 2, 5));
        exp_q.push_back(ev(0, 1, 1, 3, 13));
        tick_pulse();
        wait_slot(1, 10, "t4_reach_slot1");
        bus.ts_time_2 = 16'd8;
        wait_busy_low(30, "t4_frame_ends");

        // Slot 2 period changed while slot 2 runs
        bus.ts_time_2 = 16'd4;
        exp_q.push_back(ev(1, 1, 0, 0, 1));
        exp_q.push_back(ev(0, 1, 0, 1, 3));
        exp_q.push_back(ev(0, 1, 0, 2, 5));
        exp_q.push_back(ev(0, 1, 1, 3, 9));
        tick_pulse();
        wait_slot(2, 10, "t5_reach_slot2");
        bus.ts_time_2 = 16'd8;
        wait_busy_low(30, "t5_frame_ends");

        // 300 dropped triggers saturate the overrun counter
        set_ts(400, 0, 0, 0);
        bus.in_sync_div = 16'd1;
        exp_q.push_back(ev(1, 1, 0, 0, 1));
        exp_q.push_back(ev(0, 1, 0, 1, 401));
        exp_q.push_back(ev(0, 1, 0, 2, 402));
        exp_q.push_back(ev(0, 1, 1, 3, 403));
        tick_pulse();
        bus.tick = 1'b1;
        step(100);
        check("t6_overrun_101", int'(bus.overrun_cnt), 101);
        step(200);
        check("t6_overrun_sat", int'(bus.overrun_cnt), 255);
        bus.tick = 1'b0;
        wait_busy_low(400, "t6_frame_ends");

        // Sync disabled mid-frame: frame completes, nothing follows
        set_ts(2, 2, 2, 2);
        exp_q.push_back(ev(1, 1, 0, 0, 1));
        exp_q.push_back(ev(0, 1, 0, 1, 3));
        exp_q.push_back(ev(0, 1, 0, 2, 5));
        exp_q.push_back(ev(0, 1, 0, 3, 7));
        exp_q.push_back(ev(0, 0, 1, 3, 8));
        tick_pulse();
        bus.sync_enabled = 1'b0;
        bus.tick = 1'b1;
        wait_busy_low(20, "t7_frame_ends");
        step(20);
        bus.tick = 1'b0;
        check("t7_no_new_frame", int'(bus.busy), 0);
        check("t7_overrun_held", int'(bus.overrun_cnt), 255);

        // Reset during slot 2: no frame_done, immediate clear
        bus.sync_enabled = 1'b1;
        exp_q.push_back(ev(1, 1, 0, 0, 1));
        exp_q.push_back(ev(0, 1, 0, 1, 3));
        exp_q.push_back(ev(0, 1, 0, 2, 5));
        tick_pulse();
        wait_slot(2, 10, "t8_reach_slot2");
        step(1);
        rst_n = 1'b0;
        #1;
        check("t8_rst_slot", int'(bus.slot), 0);
        check("t8_rst_busy", int'(bus.busy), 0);
        check("t8_rst_pulses", int'({bus.slot_start, bus.frame_start, bus.frame_done}), 0);
        check("t8_rst_ovr", int'(bus.overrun_cnt), 0);
        step(3);
        rst_n = 1'b1;
        step(5);
        check("t8_idle_after_reset", int'(bus.busy), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
